hs_src_ctrl: RTL and testbench

//   Source-side launcher for the toggle-free pulse CDC handshake; lives in the clkx (source) domain.

---
 rtl/hs_src_ctrl_pkg.sv | 18 +
 rtl/hs_src_ctrl_if.sv | 23 ++
 rtl/hs_src_ctrl_gap_cnt.sv | 31 +++
 rtl/hs_src_ctrl.sv | 156 +++++++++++++++
 tb/tb_hs_src_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hs_src_ctrl_pkg.sv
// Shared types and sizing helpers for the toggle-free pulse CDC handshake (source and destination sides).
package hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_LAUNCH = 2'd1,
        HS_WAIT   = 2'd2
    } hs_state_t;

    localparam int unsigned HS_GAP_MIN = 2;
    localparam int unsigned HS_GAP_MAX = 255;

    // Width of a counter that must be able to hold max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hs_src_ctrl_if.sv
// Word stream in, held din/din_vld launch out, synced ack back, plus status for the source launcher.
interface hs_src_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_vld;
    logic                  ack_in;
    logic                  busy;
    logic                  timeout;

    modport master (
        output s_data, s_valid, ack_in,
        input  s_ready, din, din_vld, busy, timeout
    );

    modport slave (
        input  s_data, s_valid, ack_in,
        output s_ready, din, din_vld, busy, timeout
    );
endinterface

// File: rtl/hs_src_ctrl_gap_cnt.sv
// Saturating up-counter; clr restarts from zero and may count in the same cycle.
module hs_gap_cnt
    import hs_pkg::*;
#(
    parameter int unsigned MAX_VAL = 6,
    parameter int unsigned W       = cnt_w(MAX_VAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] base_c;

    always_comb begin
        base_c = clr ? '0 : cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (base_c != W'(MAX_VAL))) begin
            cnt <= base_c + W'(1);
        end else begin
            cnt <= base_c;
        end
    end

endmodule

// File: rtl/hs_src_ctrl.sv
// Source-side launcher of the pulse CDC handshake: accepts one word, holds it on din, pulses din_vld,
// waits for the synced ack and the minimum pulse gap. Optional ack timeout under HS_ACK_TIMEOUT_EN.
module hs_src_ctrl
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned GAP_CYCLES     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    hs_src_ctrl_if.slave  bus
);

    localparam int unsigned GAP_W = cnt_w(GAP_CYCLES);

    if ((GAP_CYCLES < HS_GAP_MIN) || (GAP_CYCLES > HS_GAP_MAX) || (TIMEOUT_CYCLES < GAP_CYCLES)) begin : g_cfg_err
        $error("hs_src_ctrl: illegal GAP_CYCLES/TIMEOUT_CYCLES");
    end

    hs_state_t             state;
    hs_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  din_vld_q;
    logic                  s_ready_q;
    logic                  busy_q;
    logic                  ack_q;
    logic                  ack_seen;
    logic                  ack_seen_nxt;
    logic                  accept_c;
    logic                  rise_c;
    logic                  gap_done_c;
    logic [GAP_W-1:0]      gap_cnt;

    // s_ready_q is only high in IDLE, and stays low for the first cycle after reset.
    assign accept_c   = s_ready_q && bus.s_valid;
    assign rise_c     = bus.ack_in && !ack_q;
    assign gap_done_c = (gap_cnt == GAP_W'(GAP_CYCLES));

    // Loads 1 on accept so the launch cycle counts as the first gap cycle.
    hs_gap_cnt #(
        .MAX_VAL (GAP_CYCLES),
        .W       (GAP_W)
    ) u_gap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == HS_IDLE),
        .inc (accept_c || (state != HS_IDLE)),
        .cnt (gap_cnt)
    );

`ifdef HS_ACK_TIMEOUT_EN
    localparam int unsigned TO_W = cnt_w(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit_nxt;
    logic            timeout_q;

    hs_gap_cnt #(
        .MAX_VAL (TIMEOUT_CYCLES),
        .W       (TO_W)
    ) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == HS_IDLE),
        .inc (state != HS_IDLE),
        .cnt (to_cnt)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ack_seen_nxt = ack_seen;
`ifdef HS_ACK_TIMEOUT_EN
        to_hit_nxt   = 1'b0;
`endif
        case (state)
            HS_IDLE: begin
                // Ack edges here are stale or stray.
                ack_seen_nxt = 1'b0;
                if (accept_c) begin
                    state_nxt = HS_LAUNCH;
                end
            end
            HS_LAUNCH: begin
                ack_seen_nxt = ack_seen || rise_c;
                state_nxt    = HS_WAIT;
            end
            HS_WAIT: begin
                ack_seen_nxt = ack_seen || rise_c;
                if (ack_seen && gap_done_c) begin
                    state_nxt = HS_IDLE;
`ifdef HS_ACK_TIMEOUT_EN
                end else if (timeout_q) begin
                    state_nxt = HS_IDLE;
                end else if (!ack_seen_nxt && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    // Registered so the pulse lands in the cycle to_cnt reaches the limit.
                    to_hit_nxt = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = HS_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state; din only moves on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q     <= '0;
            din_vld_q <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            ack_seen  <= 1'b0;
        end else begin
            if (accept_c) begin
                din_q <= bus.s_data;
            end
            din_vld_q <= (state_nxt == HS_LAUNCH);
            s_ready_q <= (state_nxt == HS_IDLE);
            busy_q    <= (state_nxt != HS_IDLE);
            ack_q     <= bus.ack_in;
            ack_seen  <= ack_seen_nxt;
        end
    end

`ifdef HS_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit_nxt;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.din     = din_q;
    assign bus.din_vld = din_vld_q;
    assign bus.s_ready = s_ready_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_hs_src_ctrl.sv
// Directed bench for hs_src_ctrl (GAP=6, TIMEOUT=64); timeout scenario follows HS_ACK_TIMEOUT_EN.
module tb_hs_src_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    hs_src_ctrl_if #(.DATA_WIDTH(8)) bus ();

    hs_src_ctrl #(
        .DATA_WIDTH     (8),
        .GAP_CYCLES     (6),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pulse(input string tag, output int at);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.din_vld && n < 40);
        check_eq(tag, 32'(bus.din_vld), 32'd1);
        at = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p;
        int last;

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.ack_in  = 1'b0;
        repeat (3) tick();
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check_eq("rst_din",     32'(bus.din),     32'd0);
        check_eq("rst_din_vld", 32'(bus.din_vld), 32'd0);
        check_eq("rst_busy",    32'(bus.busy),    32'd0);
        check_eq("rst_timeout", 32'(bus.timeout), 32'd0);

        // 1: word A5 offered straight out of reset
        rst         = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        tick();
        check_eq("t1_ready_after_rst", 32'(bus.s_ready), 32'd1);
        check_eq("t1_no_early_pulse",  32'(bus.din_vld), 32'd0);
        tick();
        p = cyc;
        check_eq("t1_din",     32'(bus.din),     32'hA5);
        check_eq("t1_pulse",   32'(bus.din_vld), 32'd1);
        check_eq("t1_ready_0", 32'(bus.s_ready), 32'd0);
        check_eq("t1_busy",    32'(bus.busy),    32'd1);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // 2: ack 3 cycles after the pulse; ready must wait for the gap (6 cycles)
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 1) check_eq("t1_pulse_one_cycle", 32'(bus.din_vld), 32'd0);
            if (j == 3) bus.ack_in = 1'b1;
            if (j == 4) bus.ack_in = 1'b0;
            check_eq($sformatf("t2_ready_p%0d", j), 32'(bus.s_ready), (j == 6) ? 32'd1 : 32'd0);
        end
        check_eq("t2_din_held", 32'(bus.din),  32'hA5);
        check_eq("t2_busy_0",   32'(bus.busy), 32'd0);

        // 3: streaming words 1,2,3 with late ack -> pulses 11 cycles apart
        bus.s_data  = 8'd1;
        bus.s_valid = 1'b1;
        last = 0;
        for (int w = 1; w <= 3; w++) begin
            wait_pulse($sformatf("t3_pulse_w%0d", w), p);
            check_eq($sformatf("t3_din_w%0d", w), 32'(bus.din), 32'(w));
            if (w > 1) check_eq($sformatf("t3_spacing_w%0d", w), 32'(p - last), 32'd11);
            last = p;
            if (w < 3) bus.s_data = 8'(w + 1);
            else       bus.s_valid = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                tick();
                if (j == 4) begin
                    check_eq($sformatf("t3_hold_w%0d", w),  32'(bus.din),     32'(w));
                    check_eq($sformatf("t3_ready_w%0d", w), 32'(bus.s_ready), 32'd0);
                end
            end
            bus.ack_in = 1'b1;
            tick();
            bus.ack_in = 1'b0;
        end
        repeat (3) tick();
        check_eq("t3_idle_ready", 32'(bus.s_ready), 32'd1);
        check_eq("t3_idle_busy",  32'(bus.busy),    32'd0);

        // 4: ack held high from IDLE is not an edge; only a fresh rise completes
        bus.ack_in = 1'b1;
        repeat (2) tick();
        bus.s_data  = 8'h3C;
        bus.s_valid = 1'b1;
        wait_pulse("t4_pulse", p);
        check_eq("t4_din", 32'(bus.din), 32'h3C);
        bus.s_valid = 1'b0;
        repeat (10) tick();
        check_eq("t4_no_exit_ready", 32'(bus.s_ready), 32'd0);
        check_eq("t4_no_exit_busy",  32'(bus.busy),    32'd1);
        bus.ack_in = 1'b0;
        tick();
        bus.ack_in = 1'b1;
        tick();
        check_eq("t4_ready_not_yet", 32'(bus.s_ready), 32'd0);
        tick();
        check_eq("t4_ready_after_edge", 32'(bus.s_ready), 32'd1);
        bus.ack_in = 1'b0;
        tick();

        // 5: reset in WAIT aborts, then a new word launches normally
        bus.s_data  = 8'h5A;
        bus.s_valid = 1'b1;
        wait_pulse("t5_pulse_a", p);
        bus.s_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_eq("t5_rst_ready",   32'(bus.s_ready), 32'd0);
        check_eq("t5_rst_din",     32'(bus.din),     32'd0);
        check_eq("t5_rst_din_vld", 32'(bus.din_vld), 32'd0);
        check_eq("t5_rst_busy",    32'(bus.busy),    32'd0);
        rst = 1'b0;
        tick();
        check_eq("t5_ready_release", 32'(bus.s_ready), 32'd1);
        bus.s_data  = 8'hC3;
        bus.s_valid = 1'b1;
        wait_pulse("t5_pulse_b", p);
        check_eq("t5_din_b", 32'(bus.din), 32'hC3);
        bus.s_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 3) bus.ack_in = 1'b1;
            if (j == 4) bus.ack_in = 1'b0;
        end
        check_eq("t5_ready_b", 32'(bus.s_ready), 32'd1);

        // 6: no ack at all
        bus.s_data  = 8'h77;
        bus.s_valid = 1'b1;
        wait_pulse("t6_pulse", p);
        bus.s_valid = 1'b0;
`ifdef HS_ACK_TIMEOUT_EN
        repeat (63) tick();
        check_eq("t6_timeout_early", 32'(bus.timeout), 32'd0);
        tick();
        check_eq("t6_timeout_pulse", 32'(bus.timeout), 32'd1);
        check_eq("t6_ready_during",  32'(bus.s_ready), 32'd0);
        tick();
        check_eq("t6_timeout_1cyc",  32'(bus.timeout), 32'd0);
        check_eq("t6_ready_after",   32'(bus.s_ready), 32'd1);
`else
        repeat (70) tick();
        check_eq("t6_busy_held",  32'(bus.busy),    32'd1);
        check_eq("t6_no_timeout", 32'(bus.timeout), 32'd0);
        check_eq("t6_no_ready",   32'(bus.s_ready), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
